// File: rtl/construtor_caminho_pkg.sv
// Shared definitions for the path builder stage (package pkg_caminho).
// FSM encoding and default sizing reused by the search core stages.
package pkg_caminho;

    localparam int ADDR_WIDTH_DEF  = 10;
    localparam int MAX_CAMINHO_DEF = 64;

    typedef enum logic [2:0] {
        OCIOSO          = 3'd0,
        EMPILHA_DESTINO = 3'd1,
        LER             = 3'd2,
        ESPERA          = 3'd3,
        AVALIA          = 3'd4,
        ENVIAR          = 3'd5,
        FIM             = 3'd6,
        ERRO            = 3'd7
    } estado_t;

    function automatic int ptr_w(input int max_c);
        return $clog2(max_c) + 1;
    endfunction

endpackage

// File: rtl/construtor_caminho_if.sv
// Path stream handshake: one node per accepted valid/ready beat.
// The master drives valid/addr/ultimo, the slave drives ready.
interface construtor_caminho_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  caminho_valid_out;
    logic [ADDR_WIDTH-1:0] caminho_addr_out;
    logic                  caminho_ultimo_out;
    logic                  caminho_ready_in;

    modport master (
        output caminho_valid_out,
        output caminho_addr_out,
        output caminho_ultimo_out,
        input  caminho_ready_in
    );

    modport slave (
        input  caminho_valid_out,
        input  caminho_addr_out,
        input  caminho_ultimo_out,
        output caminho_ready_in
    );
endinterface

// File: rtl/construtor_caminho_pilha.sv
// pilha_caminho: register-array LIFO holding the reversed path.
// Push writes [count], pop drops count, top is [count-1].
module pilha_caminho
    import pkg_caminho::*;
#(
    parameter  int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter  int MAX_CAMINHO = MAX_CAMINHO_DEF,
    localparam int PTR_WIDTH   = ptr_w(MAX_CAMINHO)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    input  logic [ADDR_WIDTH-1:0] data_i,
    output logic [ADDR_WIDTH-1:0] top_o,
    output logic [PTR_WIDTH-1:0]  count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int IW    = PTR_WIDTH - 1;
    localparam int DEPTH = 1 << IW;

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  count_q, count_d;
    logic [IW-1:0]         top_idx;

    assign full_o  = (count_q == PTR_WIDTH'(MAX_CAMINHO));
    assign empty_o = (count_q == '0);
    assign top_idx = count_q[IW-1:0] - IW'(1);
    assign top_o   = empty_o ? '0 : mem_q[top_idx];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (push_i && !full_o)
            count_d = count_q + PTR_WIDTH'(1);
        else if (pop_i && !empty_o)
            count_d = count_q - PTR_WIDTH'(1);
    end

    // Storage needs no reset: count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_i && !full_o && !clear_i)
            mem_q[count_q[IW-1:0]] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/construtor_caminho.sv
// Walks the predecessor memory from destino back to fonte, then streams fonte..destino.
// Optional CONSTRUTOR_CAMINHO_COMPRIMENTO_EN adds comprimento_out (final path length).
module construtor_caminho
    import pkg_caminho::*;
#(
    parameter  int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter  int MAX_CAMINHO = MAX_CAMINHO_DEF,
    localparam int PTR_WIDTH   = ptr_w(MAX_CAMINHO)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cme_construir_caminho_in,
    input  logic [ADDR_WIDTH-1:0] top_fonte_in,
    input  logic [ADDR_WIDTH-1:0] top_destino_in,
    output logic                  anterior_rd_en_out,
    output logic [ADDR_WIDTH-1:0] anterior_rd_addr_out,
    input  logic [ADDR_WIDTH-1:0] anterior_rd_data_in,
    construtor_caminho_if.master  caminho,
    output logic                  caminho_pronto_out,
    output logic                  caminho_lido_out,
    output logic                  ocupado_out,
`ifdef CONSTRUTOR_CAMINHO_COMPRIMENTO_EN
    output logic [PTR_WIDTH-1:0]  comprimento_out,
`endif
    output logic                  erro_out
);
    estado_t               estado_q, estado_d;
    logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
    logic [ADDR_WIDTH-1:0] destino_q, destino_d;
    logic [ADDR_WIDTH-1:0] atual_q, atual_d;
    logic                  erro_q, erro_d;

    logic                  push, pop, limpa, valid;
    logic [ADDR_WIDTH-1:0] dado_push, topo;
    logic [PTR_WIDTH-1:0]  count;
    logic                  cheio, vazio;

    pilha_caminho #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MAX_CAMINHO (MAX_CAMINHO)
    ) u_pilha (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (limpa),
        .data_i  (dado_push),
        .top_o   (topo),
        .count_o (count),
        .full_o  (cheio),
        .empty_o (vazio)
    );

    always_comb begin
        estado_d           = estado_q;
        fonte_d            = fonte_q;
        destino_d          = destino_q;
        atual_d            = atual_q;
        erro_d             = erro_q;
        push               = 1'b0;
        pop                = 1'b0;
        limpa              = 1'b0;
        dado_push          = atual_q;
        valid              = 1'b0;
        anterior_rd_en_out = 1'b0;
        caminho_lido_out   = 1'b0;
        caminho_pronto_out = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (cme_construir_caminho_in) begin
                    fonte_d   = top_fonte_in;
                    destino_d = top_destino_in;
                    erro_d    = 1'b0;
                    limpa     = 1'b1;
                    estado_d  = EMPILHA_DESTINO;
                end
            end
            EMPILHA_DESTINO: begin
                push      = 1'b1;
                dado_push = destino_q;
                atual_d   = destino_q;
                estado_d  = (destino_q == fonte_q) ? ENVIAR : LER;
            end
            LER: begin
                anterior_rd_en_out = 1'b1;
                estado_d           = ESPERA;
            end
            ESPERA: estado_d = AVALIA;
            AVALIA: begin
                // Full stack means the chain is longer than allowed or cyclic.
                if (cheio) begin
                    erro_d   = 1'b1;
                    estado_d = ERRO;
                end else begin
                    push      = 1'b1;
                    dado_push = anterior_rd_data_in;
                    atual_d   = anterior_rd_data_in;
                    estado_d  = (anterior_rd_data_in == fonte_q) ? ENVIAR : LER;
                end
            end
            ENVIAR: begin
                valid = !vazio;
                if (valid && caminho.caminho_ready_in) begin
                    pop              = 1'b1;
                    caminho_lido_out = 1'b1;
                    if (count == PTR_WIDTH'(1))
                        estado_d = FIM;
                end
            end
            FIM: begin
                caminho_pronto_out = 1'b1;
                estado_d           = OCIOSO;
            end
            ERRO: begin
                limpa    = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign anterior_rd_addr_out       = anterior_rd_en_out ? atual_q : '0;
    assign caminho.caminho_valid_out  = valid;
    assign caminho.caminho_addr_out   = valid ? topo : '0;
    assign caminho.caminho_ultimo_out = valid && (count == PTR_WIDTH'(1));
    assign ocupado_out                = (estado_q != OCIOSO);
    assign erro_out                   = erro_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            fonte_q   <= '0;
            destino_q <= '0;
            atual_q   <= '0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            fonte_q   <= fonte_d;
            destino_q <= destino_d;
            atual_q   <= atual_d;
            erro_q    <= erro_d;
        end
    end

`ifdef CONSTRUTOR_CAMINHO_COMPRIMENTO_EN
    logic [PTR_WIDTH-1:0] comp_q, comp_d;

    // Entry into ENVIAR always coincides with the final push.
    always_comb begin
        comp_d = comp_q;
        if (limpa)
            comp_d = '0;
        else if (estado_d == ENVIAR && estado_q != ENVIAR)
            comp_d = count + PTR_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            comp_q <= '0;
        else
            comp_q <= comp_d;
    end

    assign comprimento_out = comp_q;
`endif

endmodule

// File: tb/tb_construtor_caminho.sv
// Randomized bench for construtor_caminho against a list-based path model.
// Define CONSTRUTOR_CAMINHO_COMPRIMENTO_EN to also check comprimento_out.
module tb_construtor_caminho;
    localparam int AW  = 10;
    localparam int MAX = 4;
    localparam int PW  = $clog2(MAX) + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] fonte, destino;
    logic          rd_en;
    logic [AW-1:0] rd_addr, rd_data;
    logic          pronto, lido, ocupado, erro;
    logic          ready;
`ifdef CONSTRUTOR_CAMINHO_COMPRIMENTO_EN
    logic [PW-1:0] comp;
`endif

    logic [AW-1:0] pred [1024];

    int n_cmp;
    int n_bad;

    construtor_caminho_if #(.ADDR_WIDTH(AW)) cif ();
    assign cif.caminho_ready_in = ready;

    construtor_caminho #(
        .ADDR_WIDTH  (AW),
        .MAX_CAMINHO (MAX)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .cme_construir_caminho_in (start),
        .top_fonte_in             (fonte),
        .top_destino_in           (destino),
        .anterior_rd_en_out       (rd_en),
        .anterior_rd_addr_out     (rd_addr),
        .anterior_rd_data_in      (rd_data),
        .caminho                  (cif),
        .caminho_pronto_out       (pronto),
        .caminho_lido_out         (lido),
        .ocupado_out              (ocupado),
`ifdef CONSTRUTOR_CAMINHO_COMPRIMENTO_EN
        .comprimento_out          (comp),
`endif
        .erro_out                 (erro)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rd_en)
            rd_data <= pred[rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference: follow pred[] from destino until fonte, bounded by MAX nodes.
    task automatic model(input logic [AW-1:0] f, input logic [AW-1:0] d,
                         output logic [AW-1:0] path [$], output bit err,
                         output int reads);
        logic [AW-1:0] walk [$];
        logic [AW-1:0] cur;
        walk.delete();
        path.delete();
        walk.push_back(d);
        cur   = d;
        err   = 1'b0;
        reads = 0;
        while (cur != f) begin
            reads++;
            if (walk.size() == MAX) begin
                err = 1'b1;
                break;
            end
            cur = pred[cur];
            walk.push_back(cur);
        end
        if (!err)
            for (int i = walk.size() - 1; i >= 0; i--)
                path.push_back(walk[i]);
    endtask

    task automatic run_case(input logic [AW-1:0] f, input logic [AW-1:0] d,
                            input int mode, input bit rst_at_read);
        logic [AW-1:0] ref_path [$];
        bit            err;
        int            reads;
        logic [6:0]    pat;
        int            acc, lido_n, pronto_n, reads_n, valid_n;
        int            first_acc, last_acc, pronto_cyc;
        bit            hold, prev_valid, done;
        logic [AW-1:0] hold_addr;
        model(f, d, ref_path, err, reads);
        pat = 7'b1101001;
        acc = 0; lido_n = 0; pronto_n = 0; reads_n = 0; valid_n = 0;
        first_acc = -1; last_acc = -1; pronto_cyc = -1;
        hold = 1'b0; prev_valid = 1'b0; done = 1'b0;
        hold_addr = '0;
        @(negedge clk);
        fonte   = f;
        destino = d;
        start   = 1'b1;
        ready   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("erro_clr", {31'd0, erro}, 0);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            case (mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = pat[cyc % 7];
            endcase
            start = prev_valid && ($urandom_range(0, 3) == 0);
            #1;
            if (rst_at_read && rd_en) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_eq("rst_outs",
                         {20'd0, rd_addr, rd_en, cif.caminho_valid_out,
                          ocupado, erro, pronto, lido}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (rd_en)   reads_n++;
            if (lido)    lido_n++;
            if (pronto) begin
                pronto_n++;
                pronto_cyc = cyc;
            end
            if (cif.caminho_valid_out) valid_n++;
            if (hold) begin
                check_eq("hold_valid", {31'd0, cif.caminho_valid_out}, 1);
                check_eq("hold_addr", {22'd0, cif.caminho_addr_out},
                         {22'd0, hold_addr});
            end
            if (cif.caminho_valid_out && ready) begin
                if (acc < ref_path.size())
                    check_eq("node", {22'd0, cif.caminho_addr_out},
                             {22'd0, ref_path[acc]});
                check_eq("ultimo", {31'd0, cif.caminho_ultimo_out},
                         (acc == ref_path.size() - 1) ? 1 : 0);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                acc++;
            end
            hold       = cif.caminho_valid_out && !ready;
            hold_addr  = cif.caminho_addr_out;
            prev_valid = cif.caminho_valid_out;
            if (!ocupado) done = 1'b1;
        end
        start = 1'b0;
        ready = 1'b0;
        check_eq("timeout", {31'd0, done}, 1);
        check_eq("n_nodes", acc, ref_path.size());
        check_eq("lido_n", lido_n, acc);
        check_eq("pronto_n", pronto_n, err ? 0 : 1);
        check_eq("reads", reads_n, reads);
        check_eq("erro", {31'd0, erro}, {31'd0, err});
        if (err)
            check_eq("valid_on_err", valid_n, 0);
        else
            check_eq("pronto_cyc", pronto_cyc, last_acc + 1);
        if (mode == 0 && !err)
            check_eq("back2back", last_acc - first_acc, ref_path.size() - 1);
`ifdef CONSTRUTOR_CAMINHO_COMPRIMENTO_EN
        check_eq("comprimento", {29'd0, comp}, err ? 0 : ref_path.size());
`endif
    endtask

    task automatic random_case();
        logic [AW-1:0] nodes [$];
        logic [AW-1:0] v;
        int            n;
        bit            dup;
        n = $urandom_range(1, 6);
        nodes.delete();
        while (nodes.size() < n) begin
            v   = AW'($urandom_range(0, 1023));
            dup = 1'b0;
            foreach (nodes[i]) if (nodes[i] == v) dup = 1'b1;
            if (!dup) nodes.push_back(v);
        end
        for (int i = 1; i < n; i++)
            pred[nodes[i]] = nodes[i-1];
        run_case(nodes[0], nodes[n-1], $urandom_range(0, 2), 1'b0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        fonte   = '0;
        destino = '0;
        rd_data = '0;
        for (int i = 0; i < 1024; i++) pred[i] = AW'(i);
        @(posedge clk);
        #1;
        check_eq("reset_outs",
                 {20'd0, rd_addr, rd_en, cif.caminho_valid_out,
                  ocupado, erro, pronto, lido}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pred[5] = 10'd3;
        pred[3] = 10'd1;
        run_case(10'd1, 10'd5, 0, 1'b0);

        run_case(10'd7, 10'd7, 0, 1'b0);

        pred[40] = 10'd30;
        pred[30] = 10'd20;
        pred[20] = 10'd10;
        run_case(10'd10, 10'd40, 2, 1'b0);

        pred[9] = 10'd8;
        pred[8] = 10'd9;
        run_case(10'd2, 10'd9, 1, 1'b0);
        run_case(10'd1, 10'd5, 1, 1'b0);

        pred[100] = 10'd101;
        pred[101] = 10'd102;
        pred[102] = 10'd103;
        run_case(10'd103, 10'd100, 0, 1'b1);
        pred[6] = 10'd2;
        run_case(10'd2, 10'd6, 0, 1'b0);

        for (int k = 0; k < 30; k++) random_case();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
